// File: rtl/fdc_seek_ctrl.sv
// fdc_seek_ctrl: floppy seek/recalibrate sequencer with spin-up wait, direction
// setup, step pulse/rate timing and head settle before reporting status.
module fdc_seek_ctrl #(
  parameter int unsigned STEP_PW   = 50,
  parameter int unsigned STEP_RATE = 150000,
  parameter int unsigned DIR_SU    = 50,
  parameter int unsigned SETTLE    = 750000,
  parameter int unsigned SPIN_TO   = 50000000,
  parameter int unsigned MAX_TRK   = 79
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_op,
  input  logic [6:0] cmd_track,
  input  logic [1:0] cmd_drive,
  input  logic       motor_req,
  output logic [3:0] drive_sel,
  output logic       motor_on,
  output logic       dir_sel,
  output logic       step,
  input  logic       track_0,
  input  logic       index,
  input  logic       ready,
  input  logic       wr_protect,
  output logic [6:0] cur_track,
  output logic       busy,
  output logic       done,
  output logic [1:0] err,
  output logic       wp_out,
  output logic       idx_out
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SPINUP  = 3'd1;
  localparam logic [2:0] S_DIRSU   = 3'd2;
  localparam logic [2:0] S_STEP_LO = 3'd3;
  localparam logic [2:0] S_STEP_HI = 3'd4;
  localparam logic [2:0] S_SETTLE  = 3'd5;
  localparam logic [2:0] S_FIN     = 3'd6;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_NRDY  = 2'd1;
  localparam logic [1:0] ERR_RECAL = 2'd2;
  localparam logic [1:0] ERR_TRK   = 2'd3;

  function automatic logic [31:0] at_least_one(input int unsigned v);
    if (v == 32'd0) begin
      return 32'd1;
    end else begin
      return v;
    end
  endfunction

  localparam logic [31:0] T_STEP_PW = at_least_one(STEP_PW);
  localparam logic [31:0] T_STEP_HI = (STEP_RATE > T_STEP_PW) ? (STEP_RATE - T_STEP_PW) : 32'd1;
  localparam logic [31:0] T_DIR_SU  = at_least_one(DIR_SU);
  localparam logic [31:0] T_SETTLE  = at_least_one(SETTLE);
  localparam logic [31:0] T_SPIN_TO = at_least_one(SPIN_TO);
  localparam logic [6:0]  MAX_TRK_7 = MAX_TRK[6:0];
  // A recalibrate gives up after one step more than the highest track number.
  localparam logic [7:0]  RECAL_LIMIT = {1'b0, MAX_TRK_7} + 8'd1;

  logic [2:0]  state_r;
  logic [31:0] timer_r;
  logic        op_r;
  logic [6:0]  target_r;
  logic [7:0]  step_cnt_r;
  logic        abort_r;
  logic        step_r;
  logic        dir_sel_r;
  logic        motor_on_r;
  logic [3:0]  drive_sel_r;
  logic [6:0]  cur_track_r;
  logic [1:0]  err_r;
  logic        wp_r;
  logic        idx_r;
  logic [6:0]  next_trk_s;
  logic        timer_last_s;

  // Head position after one more step in the current direction, saturating.
  always_comb begin
    next_trk_s = cur_track_r;
    if (dir_sel_r) begin
      if (cur_track_r != 7'd0) begin
        next_trk_s = cur_track_r - 7'd1;
      end else begin
        next_trk_s = cur_track_r;
      end
    end else begin
      if (cur_track_r < MAX_TRK_7) begin
        next_trk_s = cur_track_r + 7'd1;
      end else begin
        next_trk_s = cur_track_r;
      end
    end
  end

  assign timer_last_s = (timer_r <= 32'd1);

  // Sequencer state, shared down-counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      timer_r     <= 32'd1;
      op_r        <= 1'b0;
      target_r    <= 7'd0;
      step_cnt_r  <= 8'd0;
      abort_r     <= 1'b0;
      step_r      <= 1'b1;
      dir_sel_r   <= 1'b0;
      motor_on_r  <= 1'b0;
      drive_sel_r <= 4'd0;
      cur_track_r <= 7'd0;
      err_r       <= ERR_OK;
      wp_r        <= 1'b0;
      idx_r       <= 1'b0;
    end else begin
      wp_r  <= wr_protect;
      idx_r <= index;
      case (state_r)
        S_IDLE: begin
          if (cmd_valid) begin
            op_r        <= cmd_op;
            target_r    <= cmd_track;
            drive_sel_r <= 4'b0001 << cmd_drive;
            motor_on_r  <= 1'b1;
            err_r       <= ERR_OK;
            abort_r     <= 1'b0;
            timer_r     <= T_SPIN_TO;
            state_r     <= S_SPINUP;
          end else begin
            motor_on_r <= motor_req;
            if (!motor_req) drive_sel_r <= 4'd0;
          end
        end
        S_SPINUP: begin
          if (ready) begin
            if (op_r) begin
              if (track_0) begin
                cur_track_r <= 7'd0;
                err_r       <= ERR_OK;
                state_r     <= S_FIN;
              end else begin
                dir_sel_r  <= 1'b1;
                step_cnt_r <= 8'd0;
                timer_r    <= T_DIR_SU;
                state_r    <= S_DIRSU;
              end
            end else if (target_r > MAX_TRK_7) begin
              err_r   <= ERR_TRK;
              state_r <= S_FIN;
            end else if (target_r == cur_track_r) begin
              err_r   <= ERR_OK;
              state_r <= S_FIN;
            end else begin
              dir_sel_r <= (target_r < cur_track_r);
              timer_r   <= T_DIR_SU;
              state_r   <= S_DIRSU;
            end
          end else if (timer_last_s) begin
            err_r   <= ERR_NRDY;
            state_r <= S_FIN;
          end else begin
            timer_r <= timer_r - 32'd1;
          end
        end
        S_DIRSU: begin
          if (!ready) begin
            err_r   <= ERR_NRDY;
            state_r <= S_FIN;
          end else if (timer_last_s) begin
            step_r      <= 1'b0;
            timer_r     <= T_STEP_PW;
            cur_track_r <= next_trk_s;
            step_cnt_r  <= step_cnt_r + 8'd1;
            state_r     <= S_STEP_LO;
          end else begin
            timer_r <= timer_r - 32'd1;
          end
        end
        S_STEP_LO: begin
          // A lost ready is remembered so the pulse and its recovery finish.
          if (!ready) abort_r <= 1'b1;
          if (timer_last_s) begin
            step_r  <= 1'b1;
            timer_r <= T_STEP_HI;
            state_r <= S_STEP_HI;
          end else begin
            timer_r <= timer_r - 32'd1;
          end
        end
        S_STEP_HI: begin
          if (timer_last_s) begin
            if (abort_r || !ready) begin
              err_r   <= ERR_NRDY;
              state_r <= S_FIN;
            end else if (track_0 && (op_r || dir_sel_r)) begin
              cur_track_r <= 7'd0;
              timer_r     <= T_SETTLE;
              state_r     <= S_SETTLE;
            end else if (op_r && (step_cnt_r >= RECAL_LIMIT)) begin
              err_r   <= ERR_RECAL;
              state_r <= S_FIN;
            end else if (!op_r && (cur_track_r == target_r)) begin
              timer_r <= T_SETTLE;
              state_r <= S_SETTLE;
            end else begin
              step_r      <= 1'b0;
              timer_r     <= T_STEP_PW;
              cur_track_r <= next_trk_s;
              step_cnt_r  <= step_cnt_r + 8'd1;
              state_r     <= S_STEP_LO;
            end
          end else begin
            if (!ready) abort_r <= 1'b1;
            timer_r <= timer_r - 32'd1;
          end
        end
        S_SETTLE: begin
          if (!ready) begin
            err_r   <= ERR_NRDY;
            state_r <= S_FIN;
          end else if (timer_last_s) begin
            err_r   <= ERR_OK;
            state_r <= S_FIN;
          end else begin
            timer_r <= timer_r - 32'd1;
          end
        end
        S_FIN: begin
          state_r <= S_IDLE;
        end
        default: begin
          step_r  <= 1'b1;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = (state_r == S_IDLE);
  assign busy      = (state_r != S_IDLE);
  assign done      = (state_r == S_FIN);
  assign step      = step_r;
  assign dir_sel   = dir_sel_r;
  assign motor_on  = motor_on_r;
  assign drive_sel = drive_sel_r;
  assign cur_track = cur_track_r;
  assign err       = err_r;
  assign wp_out    = wp_r;
  assign idx_out   = idx_r;

endmodule
